// File: rtl/video_pkg.sv
// Shared video timing constants and pixel type used by the line buffers and filter pipeline.
package video_pkg;
    localparam int PIX_W       = 24;
    localparam int LINE_ADDR_W = 12;
    localparam int LINE_LEN    = 2200;
    localparam int FRAME_LINES = 1125;

    typedef logic [PIX_W-1:0] pixel_t;
endpackage

// File: rtl/line_buffer_ram_if.sv
// Write/read bus of one line buffer: port A write, port B registered read.
interface line_buffer_ram_if import video_pkg::*; #(
    parameter int DATA_WIDTH = PIX_W,
    parameter int ADDR_WIDTH = LINE_ADDR_W
);
    logic                  wea;
    logic [ADDR_WIDTH-1:0] addra;
    logic [DATA_WIDTH-1:0] dina;
    logic [ADDR_WIDTH-1:0] addrb;
    logic [DATA_WIDTH-1:0] doutb;

    modport master (output wea, addra, dina, addrb, input doutb);
    modport slave  (input wea, addra, dina, addrb, output doutb);
endinterface

// File: rtl/line_buffer_out_stage.sv
// Optional extra output register behind the RAM read register; cleared by reset.
module line_buffer_out_stage import video_pkg::*; #(
    parameter int DATA_WIDTH = PIX_W
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic [DATA_WIDTH-1:0] d,
    output logic [DATA_WIDTH-1:0] q
);
    always_ff @(posedge clk) begin
        if (!n_rst) q <= '0;
        else        q <= d;
    end
endmodule

// File: rtl/line_buffer_ram.sv
// Simple dual-port line buffer RAM, read-first, 1-cycle read latency.
// Define LINE_BUFFER_OUT_REG_EN to add a second output register (latency 2).
module line_buffer_ram import video_pkg::*; #(
    parameter int DATA_WIDTH = PIX_W,
    parameter int ADDR_WIDTH = LINE_ADDR_W,
    parameter int DEPTH      = LINE_LEN
) (
    input  logic               clk,
    input  logic               n_rst,
    line_buffer_ram_if.slave   bus
);
    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_q;
    logic                  wr_ok;
    logic                  rd_ok;

    assign wr_ok = n_rst && bus.wea && ({1'b0, bus.addra} < DEPTH_L);
    assign rd_ok = {1'b0, bus.addrb} < DEPTH_L;

    // Array has no reset so it maps to block RAM; contents survive n_rst.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[bus.addra] <= bus.dina;
    end

    // Consumer reads ahead past the line end, so out-of-range reads give 0.
    always_ff @(posedge clk) begin
        if (!n_rst)     rd_q <= '0;
        else if (rd_ok) rd_q <= mem[bus.addrb];
        else            rd_q <= '0;
    end

`ifdef LINE_BUFFER_OUT_REG_EN
    line_buffer_out_stage #(.DATA_WIDTH(DATA_WIDTH)) u_out_stage (
        .clk   (clk),
        .n_rst (n_rst),
        .d     (rd_q),
        .q     (bus.doutb)
    );
`else
    assign bus.doutb = rd_q;
`endif
endmodule

// File: tb/tb_line_buffer_ram.sv
// Scoreboard bench for line_buffer_ram: a reference memory predicts each read, the queue aligns it to latency.
module tb_line_buffer_ram;
    import video_pkg::*;

`ifdef LINE_BUFFER_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk;
    logic n_rst;

    line_buffer_ram_if bus ();

    line_buffer_ram dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    pixel_t model [LINE_LEN];
    pixel_t exp_q [$];
    int     total;
    int     bad;

    task automatic chk(input string tag, input pixel_t got, input pixel_t exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One clock: drive inputs, predict the first-stage read, then compare the output due now.
    task automatic step(input string tag, input logic rst_n, input logic we, input int wa,
                        input pixel_t wd, input int ra);
        pixel_t s1;
        pixel_t prev;
        pixel_t exp;
        n_rst     = rst_n;
        bus.wea   = we;
        bus.addra = wa[LINE_ADDR_W-1:0];
        bus.dina  = wd;
        bus.addrb = ra[LINE_ADDR_W-1:0];
        if (!rst_n)             s1 = '0;
        else if (ra < LINE_LEN) s1 = model[ra];
        else                    s1 = '0;
        if (rst_n && we && wa < LINE_LEN) model[wa] = wd;
        exp_q.push_back(s1);
        @(posedge clk);
        #1;
        if (exp_q.size() >= LAT) begin
            prev = exp_q.pop_front();
            exp  = (LAT == 1 || rst_n) ? prev : '0;
            chk(tag, bus.doutb, exp);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < LINE_LEN; i++) model[i] = '0;
        n_rst = 1'b0;
        bus.wea = 1'b0; bus.addra = '0; bus.dina = '0; bus.addrb = '0;

        step("rst_init", 1'b0, 1'b0, 0, '0, 4095);
        step("rst_init", 1'b0, 1'b0, 0, '0, 4095);
        step("preload", 1'b1, 1'b1, 5, 24'hABCDEF, 4095);
        // Writes attempted during reset must be ignored.
        for (int i = 0; i < 3; i++) step("rst_hold", 1'b0, 1'b1, 5, 24'h000000, 5);
        step("rst_release", 1'b1, 1'b0, 0, '0, 5);
        step("rst_release2", 1'b1, 1'b0, 0, '0, 5);

        for (int a = 0; a < LINE_LEN; a++) step("fill", 1'b1, 1'b1, a, pixel_t'(a * 3), 4095);
        for (int a = 0; a < LINE_LEN; a++) step("readback", 1'b1, 1'b0, 0, '0, a);

        step("oor_rd_2200", 1'b1, 1'b0, 0, '0, 2200);
        step("oor_rd_2201", 1'b1, 1'b0, 0, '0, 2201);
        step("oor_rd_4095", 1'b1, 1'b0, 0, '0, 4095);

        step("oor_wr", 1'b1, 1'b1, 2200, 24'h123456, 4095);
        step("oor_wr_rd0", 1'b1, 1'b0, 0, '0, 0);
        step("oor_wr_rd2200", 1'b1, 1'b0, 0, '0, 2200);
        step("oor_wr_rd152", 1'b1, 1'b0, 0, '0, 152);

        step("coll_pre", 1'b1, 1'b1, 10, 24'h111111, 4095);
        step("coll_same", 1'b1, 1'b1, 10, 24'h222222, 10);
        step("coll_next", 1'b1, 1'b0, 0, '0, 10);

        step("we0_drive", 1'b1, 1'b0, 7, 24'hFFFFFF, 4095);
        step("we0_read", 1'b1, 1'b0, 0, '0, 7);
        step("drain", 1'b1, 1'b0, 0, '0, 4095);
        step("drain", 1'b1, 1'b0, 0, '0, 4095);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
